// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response bundle between the MEM stage (master) and
//                the data-memory responder (slave).
//                  mem_r_en, mem_w_en : read / write request (master -> slave)
//                  address            : byte address        (master -> slave)
//                  dataToWrite        : write data          (master -> slave)
//                  result             : registered read data (slave -> master)
//                  ready              : one-cycle completion (slave -> master)
//                  freeze             : pipeline stall       (slave -> master)
//                  err                : access error, only with DMEM_ERR_EN
//  Options     : DMEM_ERR_EN adds the err signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] dataToWrite;
    logic [31:0] result;
    logic        ready;
    logic        freeze;
`ifdef DMEM_ERR_EN
    logic        err;
`endif

    modport master (
        output mem_r_en, mem_w_en, address, dataToWrite,
        input  result, ready, freeze
`ifdef DMEM_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, dataToWrite,
        output result, ready, freeze
`ifdef DMEM_ERR_EN
        , output err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Responder end of the MEM-stage data-memory interface. A
//                request seen in IDLE is latched and serviced from a word
//                array after WAIT_CYCLES wait states; freeze stalls the
//                pipeline meanwhile and ready strobes for one cycle at the end.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - data_mem_responder_if.slave (request inputs, result,
//                       ready, freeze, and err when DMEM_ERR_EN is defined)
//  Parameters  : DEPTH       - number of 32-bit words (power of 2)
//                BASE_ADDR   - byte address mapped to word 0
//                WAIT_CYCLES - wait states per access, 1..15
//  Options     : DMEM_ERR_EN - adds err; misaligned accesses become errors
//                (write dropped, read returns 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input wire                  clk,
    input wire                  rst,
    data_mem_responder_if.slave bus
);

    localparam int          c_IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] c_BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] c_SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_WAIT = 2'd1;
    localparam state_t c_DONE = 2'd2;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_ready;

    logic [3:0]           r_cnt;
    logic                 r_is_write;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_wdata;
    logic                 r_ok;        // latched access may touch the array
    logic [31:0]          r_result;
    logic [31:0]          r_mem [DEPTH];

    logic                 w_req;
    logic [31:0]          w_offset;
    logic                 w_in_range;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_ok;
    logic                 w_commit;

    // ------------------------------------------------------------------
    // Request decode (only consumed in IDLE)
    // ------------------------------------------------------------------
    assign w_req      = bus.mem_r_en | bus.mem_w_en;
    assign w_offset   = bus.address - c_BASE;
    // The lower-bound compare keeps addresses below the base from aliasing
    // through the wrapped subtraction.
    assign w_in_range = (bus.address >= c_BASE) && (w_offset < c_SPAN);
    assign w_idx      = w_offset[c_IDX_W+1:2];

`ifdef DMEM_ERR_EN
    assign w_ok = w_in_range && (bus.address[1:0] == 2'b00);
`else
    assign w_ok = w_in_range;
`endif

    // Array/result update happens on the WAIT->DONE edge.
    assign w_commit = (r_state == c_WAIT) && (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_ready      = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_ok       <= 1'b0;
        end else if ((r_state == c_IDLE) && w_req) begin
            r_cnt      <= c_CNT_LOAD;
            r_is_write <= bus.mem_w_en;   // write wins when both are set
            r_idx      <= w_idx;
            r_wdata    <= bus.dataToWrite;
            r_ok       <= w_ok;
        end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt      <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Word array; cleared by reset so a reset mid-access leaves nothing behind
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_commit && r_is_write && r_ok) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // result changes only on read completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
        end else if (w_commit && !r_is_write) begin
            r_result <= r_ok ? r_mem[r_idx] : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.result = r_result;
    assign bus.ready  = w_ready;
    assign bus.freeze = w_req & ~w_ready;

`ifdef DMEM_ERR_EN
    // r_ok already folds in range and alignment, so err is its inverse in DONE.
    assign bus.err = w_ready & ~r_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench. Two responders (WAIT_CYCLES 3 and 1)
//                share clk/rst; one is driven at a time. Expected values come
//                from a word-array model indexed with plain arithmetic.
//  Options     : DMEM_ERR_EN - also checks err and error-style misalignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int  c_DEPTH = 64;
    localparam int  c_BASE  = 1024;
    localparam int  c_W_A   = 3;
    localparam int  c_W_B   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        sel    = 1'b0;
    logic        d_r    = 1'b0;
    logic        d_w    = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_data = 32'd0;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [2][c_DEPTH];
    logic [31:0] ref_res [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if if_a ();
    data_mem_responder_if if_b ();

    assign if_a.mem_r_en    = ~sel & d_r;
    assign if_a.mem_w_en    = ~sel & d_w;
    assign if_a.address     = d_addr;
    assign if_a.dataToWrite = d_data;
    assign if_b.mem_r_en    = sel & d_r;
    assign if_b.mem_w_en    = sel & d_w;
    assign if_b.address     = d_addr;
    assign if_b.dataToWrite = d_data;

    data_mem_responder #(.DEPTH(c_DEPTH), .BASE_ADDR(c_BASE), .WAIT_CYCLES(c_W_A)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    data_mem_responder #(.DEPTH(c_DEPTH), .BASE_ADDR(c_BASE), .WAIT_CYCLES(c_W_B)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    logic        o_ready;
    logic        o_freeze;
    logic [31:0] o_result;
    assign o_ready  = sel ? if_b.ready  : if_a.ready;
    assign o_freeze = sel ? if_b.freeze : if_a.freeze;
    assign o_result = sel ? if_b.result : if_a.result;
`ifdef DMEM_ERR_EN
    logic        o_err;
    assign o_err    = sel ? if_b.err    : if_a.err;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // --- reference model ------------------------------------------------
    function automatic bit ref_in_range(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= c_BASE) && (la < c_BASE + 4 * c_DEPTH);
    endfunction

    function automatic bit ref_ok(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return ref_in_range(a) && (a % 4 == 0);
`else
        return ref_in_range(a);
`endif
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((longint'(a) - c_BASE) / 4);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            ref_res[s] = 32'd0;
            for (int i = 0; i < c_DEPTH; i++) ref_mem[s][i] = 32'd0;
        end
    endtask

    // One access on DUT s; checks ready/freeze/result (and err) every cycle
    // from the request cycle through DONE. Returns the cycle number of DONE.
    task automatic access(input logic s, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int done_cyc);
        int          w;
        bit          ok;
        logic [31:0] prev;
        w    = s ? c_W_B : c_W_A;
        ok   = ref_ok(addr);
        prev = ref_res[s];
        if (wr) begin
            if (ok) ref_mem[s][ref_idx(addr)] = data;
        end else begin
            ref_res[s] = ok ? ref_mem[s][ref_idx(addr)] : 32'd0;
        end
        @(negedge clk);
        sel = s; d_r = rd; d_w = wr; d_addr = addr; d_data = data;
        done_cyc = -1;
        for (int k = 0; k <= w + 1; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("ready", {31'd0, o_ready}, {31'd0, k == w + 1});
            check("freeze", {31'd0, o_freeze}, {31'd0, k <= w});
`ifdef DMEM_ERR_EN
            check("err", {31'd0, o_err}, {31'd0, (k == w + 1) && !ok});
`endif
            if (k == w + 1) begin
                check("result", o_result, ref_res[s]);
                done_cyc = cyc;
                d_r = 1'b0;
                d_w = 1'b0;
            end else begin
                check("result_hold", o_result, prev);
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
        check({tag, "_freeze"}, {31'd0, o_freeze}, 32'd0);
    endtask

    initial begin
        int c1, c2, c3, c4;
        logic [31:0] a;
        logic rd, wr;

        model_clear();
        // 1. reset held two cycles, first read
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_result", o_result, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_freeze", {31'd0, o_freeze}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, c1);

        // 2. write then read back; neighbour still zero
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, c1);
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, c1);
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, c1);

        // 3. both enables -> write
        access(1'b0, 1'b1, 1'b1, 32'd1024, 32'h5, c1);
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, c1);

        // 4. out-of-range writes dropped
        access(1'b0, 1'b0, 1'b1, 32'd1020, 32'h1111, c1);
        access(1'b0, 1'b0, 1'b1, 32'd1280, 32'h2222, c1);
        access(1'b0, 1'b1, 1'b0, 32'd1020, 32'd0, c1);
        access(1'b0, 1'b1, 1'b0, 32'd1276, 32'd0, c1);
        idle_check("idle");

        // 5. reset in the second WAIT cycle of a write
        @(negedge clk);
        sel = 1'b0; d_w = 1'b1; d_addr = 32'd1024; d_data = 32'h77;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_w = 1'b0;
        model_clear();
        #1;
        check("abort_ready", {31'd0, o_ready}, 32'd0);
        check("abort_result", o_result, 32'd0);
        idle_check("abort");
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, c1);

        // 6. WAIT_CYCLES=1 back-to-back
        access(1'b1, 1'b0, 1'b1, 32'd1024, 32'hA5A5_0001, c1);
        access(1'b1, 1'b0, 1'b1, 32'd1028, 32'hA5A5_0002, c2);
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, c3);
        access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, c4);
        check("spacing_w", c2 - c1, 32'd3);
        check("spacing_r1", c3 - c2, 32'd3);
        check("spacing_r2", c4 - c3, 32'd3);
        access(1'b1, 1'b1, 1'b0, 32'd1026, 32'd0, c1);

        // randomized traffic on both instances
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0: a = 32'(c_BASE + 4 * $urandom_range(0, c_DEPTH - 1));
                1: a = 32'(c_BASE + 4 * $urandom_range(0, c_DEPTH - 1) + $urandom_range(1, 3));
                2: a = ($urandom_range(0, 1) == 0)
                       ? 32'(c_BASE - 4 * $urandom_range(1, 4))
                       : 32'(c_BASE + 4 * c_DEPTH + 4 * $urandom_range(0, 4));
                default: a = 32'(c_BASE + 4 * $urandom_range(0, 7));
            endcase
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            access(1'($urandom_range(0, 1)), rd, wr, a, $urandom, c1);
        end

        // sweep both arrays for the low words
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, 1'b0, 32'(c_BASE + 4 * i), 32'd0, c1);
            access(1'b1, 1'b1, 1'b0, 32'(c_BASE + 4 * i), 32'd0, c1);
        end
        idle_check("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
